router_out_port_tx: RTL

//   Router output-port transmitter: drives one link (data/valid) into a neighbour's input FIFO, obeying its full flag.

---
 rtl/router_out_port_tx.sv | 114 +++++++++++
 1 files changed

// File: rtl/router_out_port_tx.sv
// Router output-port transmitter: buffers crossbar flits and drives one link into a
// neighbour input FIFO under its full flag, with packet framing checks, traffic count and stall detection.
module router_out_port_tx #(
  parameter int DATASIZE    = 40,
  parameter int BUF_DEPTH   = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int STALL_LIMIT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATASIZE-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATASIZE-1:0]  data_out,
  output logic                 valid_out,
  input  logic                 full_in,
  input  logic                 err_clr,
  output logic                 pkt_open,
  output logic                 proto_err,
  output logic                 stall_flag,
  output logic [CNT_WIDTH-1:0] flit_cnt
);

  localparam int AW = $clog2(BUF_DEPTH);

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {IDLE, PKT} state_t;

  logic [DATASIZE-1:0]  mem [BUF_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 buf_empty, buf_full, push, pop;
  logic [1:0]           ftype;
  state_t               state, state_nxt;
  logic                 err_set;
  logic [CNT_WIDTH-1:0] stall_cnt, stall_nxt;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign buf_empty = (wr_ptr == rd_ptr);
  assign buf_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready  = rst_n && !buf_full;
  assign push      = in_valid && in_ready;
  assign valid_out = !buf_empty && !full_in;
  assign pop       = valid_out;
  assign data_out  = mem[rd_ptr[AW-1:0]];
  assign ftype     = data_out[DATASIZE-1 -: 2];
  assign pkt_open  = (state == PKT);

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    if (pop) begin
      case (state)
        IDLE: begin
          if (ftype == T_HEAD) state_nxt = PKT;
          else if (ftype != T_SINGLE) err_set = 1'b1;
        end
        PKT: begin
          case (ftype)
            T_TAIL:   state_nxt = IDLE;
            T_HEAD:   err_set = 1'b1;
            T_SINGLE: begin
              state_nxt = IDLE;
              err_set   = 1'b1;
            end
            default:  state_nxt = PKT;
          endcase
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    stall_nxt = '0;
    if (!buf_empty && full_in) begin
      stall_nxt = (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
    end
  end

  // Buffer storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state      <= IDLE;
      proto_err  <= 1'b0;
      flit_cnt   <= '0;
      stall_cnt  <= '0;
      stall_flag <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        flit_cnt <= flit_cnt + 1'b1;
      end
      state <= state_nxt;
      // A new framing error takes priority over a clear in the same cycle.
      if (err_set)      proto_err <= 1'b1;
      else if (err_clr) proto_err <= 1'b0;
      stall_cnt  <= stall_nxt;
      stall_flag <= (stall_nxt >= CNT_WIDTH'(STALL_LIMIT));
    end
  end

endmodule
